core_mc: RTL and testbench
==========================

CORE_MC -- requirements
Module: core_mc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first instruction fetched after reset.
REQ-002 Parameter NREGS, default 32: number of implemented registers, 16 or 32; x0 is included in the count.
REQ-003 Parameter MEM_TIMEOUT, default 0: a nonzero value N aborts a memory wait after N cycles; 0 disables the timeout.
REQ-004 Port clk, input, 1 bit: the single clock; every state change happens on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port last_pc, input, 32 bits: the core halts after retiring the instruction at this address.
REQ-007 Ports instr_req (output, 1 bit), instr_addr (output, 32 bits), instr_data (input, 32 bits), instr_ack (input, 1 bit): instruction-fetch handshake.
REQ-008 Ports mem_re, mem_we (outputs, 1 bit each), mem_addr, mem_wdata (outputs, 32 bits each), mem_rdata (input, 32 bits), mem_ack (input, 1 bit): data-memory handshake.
REQ-009 Ports retire (output, 1 bit), halted (output, 1 bit), fault (output, 1 bit): status outputs.

Function
REQ-010 The core SHALL be a multi-cycle RV32I-subset core controlled by an FSM with states FETCH, EXEC, MEM and HALT.
- Supported instructions: ADD, SUB, AND, OR, XOR, SLL, SRL, SLT, ADDI, ANDI, ORI, XORI, SLTI, LW, SW, BEQ, BNE, JAL, LUI.
REQ-011 In FETCH, the core SHALL drive instr_req=1 and instr_addr=pc.
- Both signals are held stable until the cycle in which instr_ack=1.
- In that cycle the core latches instr_data into the instruction register and moves to EXEC.
REQ-012 In EXEC, which lasts exactly one cycle, the core SHALL decode the instruction, sign-extend the I/S/B/J immediates to 32 bits, and evaluate the ALU.
- All ALU arithmetic is modulo 2^32.
- Shift amount is the low 5 bits of the operand.
- SLT is a signed comparison.
REQ-013 For non-memory instructions, EXEC SHALL write rd, update pc and pulse retire for one cycle.
- pc becomes pc+4, or the branch/JAL target when taken.
- JAL writes pc+4 to rd.
REQ-014 For LW and SW, EXEC SHALL go to MEM. In MEM:
- mem_addr = rs1+imm.
- SW asserts mem_we=1 and drives mem_wdata=rs2.
- LW asserts mem_re=1.
- All of these are held until mem_ack=1.
- On the mem_ack cycle, LW writes mem_rdata to rd, pc becomes pc+4, and retire pulses.
REQ-015 mem_re and mem_we SHALL never both be 1 in the same cycle, and both SHALL be 0 outside MEM.
REQ-016 Register x0 SHALL always read as 0, and writes to it SHALL be discarded.
- With NREGS=16, indices 16-31 read as 0 and writes to them are discarded.
REQ-017 Register reads SHALL be combinational. A write made in cycle t SHALL be visible to an instruction executed in cycle t+1 or later.
REQ-018 An undefined opcode SHALL execute as a NOP: no register write, pc+4, retire pulses.
REQ-019 If the retiring instruction's pc equals last_pc, the core SHALL enter HALT in place of FETCH.
- halted=1 from the next cycle onward.
- In HALT: no requests are issued, pc is frozen, and the state stays HALT until rst.
REQ-020 With MEM_TIMEOUT=N>0, a memory wait SHALL be aborted if N consecutive MEM cycles pass without mem_ack.
- The core sets fault=1, enters HALT, and does not write a register.
REQ-021 An instr_ack or mem_ack arriving in a state that is not waiting for it SHALL be ignored.
REQ-022 Throughput SHALL be as follows, given a same-cycle ack:
- ALU, branch and JAL instructions: 2 cycles each.
- Loads and stores: 3 cycles each.

Reset
REQ-023 When rst=1 at a clock edge, the core SHALL set state=FETCH, pc=RESET_PC, all registers=0, and the instruction register=0 (a NOP).
- Outputs after reset: instr_req=1, mem_re=0, mem_we=0, retire=0, halted=0, fault=0.
REQ-024 A reset in the middle of an operation SHALL abandon any outstanding fetch or memory access.
- No register write and no retire occurs for the abandoned instruction.
REQ-025 Reset SHALL have priority over every other event in the same cycle, including an ack.

Verification
REQ-026 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2, with last_pc=8 and acks always 1:
- Required: x3=2, three retire pulses, halted=1 at cycle 7 after reset release.
REQ-027 SW x1,4(x0) with x1=0xDEADBEEF, then LW x4,4(x0), with mem_ack delayed 3 cycles:
- Required: a single write of 0xDEADBEEF to mem_addr=4.
- Required: x4=0xDEADBEEF.
- Required: mem_* signals stable throughout each wait.
REQ-028 BNE x1,x0,-4 looped, with x1 decremented from 3 by ADDI:
- Required: the branch is taken twice, then falls through.
- Required: pc sequence matches the golden model.
REQ-029 MEM_TIMEOUT=4, LW with mem_ack held at 0:
- Required: fault=1 and halted=1 after the 4th MEM cycle.
- Required: rd unchanged.
REQ-030 rst asserted during a MEM wait while mem_ack=1 in the same cycle:
- Required: no register write.
- Required: pc=RESET_PC, instr_req=1 on the following cycle.
REQ-031 NREGS=16, ADDI x20,x0,7 then ADD x5,x20,x0:
- Required: x5=0.

Source files
------------

// File: rtl/core_mc_if.sv
// Instruction-fetch and data-memory handshake bundle for core_mc.
// The core drives requests through master; the memory system answers through slave.
interface core_mc_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        instr_ack;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output instr_req, instr_addr, mem_re, mem_we, mem_addr, mem_wdata,
    input  instr_data, instr_ack, mem_rdata, mem_ack
  );

  modport slave (
    input  instr_req, instr_addr, mem_re, mem_we, mem_addr, mem_wdata,
    output instr_data, instr_ack, mem_rdata, mem_ack
  );
endinterface

// File: rtl/core_mc.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC (-> MEM) -> FETCH, or HALT after last_pc
// retires or a data-memory wait times out.
module core_mc #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      last_pc,
  core_mc_if.master        bus,
  output logic             retire,
  output logic             halted,
  output logic             fault
);
  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] ir, ir_d;
  logic [31:0] tcnt, tcnt_d;
  logic        fault_q, fault_set;
  logic        rf_we;
  logic [31:0] rf_wd;
  logic [31:0] rf [NREGS];

  function automatic logic reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && ({27'd0, idx} < NREGS);
  endfunction

  function automatic logic [31:0] slt(input logic signed [31:0] a, input logic signed [31:0] b);
    return (a < b) ? 32'd1 : 32'd0;
  endfunction

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] a, b, imm_i, imm_s, imm_b, imm_j, imm_u, pc4;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign pc4   = pc + 32'd4;

  // x0 and unimplemented indices read as zero
  assign a = reg_ok(rs1) ? rf[rs1[AW-1:0]] : '0;
  assign b = reg_ok(rs2) ? rf[rs2[AW-1:0]] : '0;

  logic        ex_wen, is_ld, is_st;
  logic [31:0] ex_wd, ex_nxt;

  always_comb begin
    ex_wen = 1'b0;
    ex_wd  = '0;
    ex_nxt = pc4;
    is_ld  = 1'b0;
    is_st  = 1'b0;
    case (opc)
      OPC_OP: begin
        ex_wen = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: ex_wd = a + b;
          {7'h20, 3'b000}: ex_wd = a - b;
          {7'h00, 3'b001}: ex_wd = a << b[4:0];
          {7'h00, 3'b010}: ex_wd = slt(a, b);
          {7'h00, 3'b100}: ex_wd = a ^ b;
          {7'h00, 3'b101}: ex_wd = a >> b[4:0];
          {7'h00, 3'b110}: ex_wd = a | b;
          {7'h00, 3'b111}: ex_wd = a & b;
          default:         ex_wen = 1'b0;
        endcase
      end
      OPC_IMM: begin
        ex_wen = 1'b1;
        case (f3)
          3'b000:  ex_wd = a + imm_i;
          3'b010:  ex_wd = slt(a, imm_i);
          3'b100:  ex_wd = a ^ imm_i;
          3'b110:  ex_wd = a | imm_i;
          3'b111:  ex_wd = a & imm_i;
          default: ex_wen = 1'b0;
        endcase
      end
      OPC_LUI: begin
        ex_wen = 1'b1;
        ex_wd  = imm_u;
      end
      OPC_JAL: begin
        ex_wen = 1'b1;
        ex_wd  = pc4;
        ex_nxt = pc + imm_j;
      end
      OPC_BR: begin
        if ((f3 == 3'b000 && a == b) || (f3 == 3'b001 && a != b))
          ex_nxt = pc + imm_b;
      end
      OPC_LD:  is_ld = (f3 == 3'b010);
      OPC_ST:  is_st = (f3 == 3'b010);
      default: ;
    endcase
  end

  // Address and store data come straight from ir and the register file, which
  // cannot change while the core sits in MEM, so they stay stable during a wait.
  assign bus.instr_req  = (state == FETCH);
  assign bus.instr_addr = pc;
  assign bus.mem_re     = (state == MEM) && is_ld;
  assign bus.mem_we     = (state == MEM) && is_st;
  assign bus.mem_addr   = a + (is_st ? imm_s : imm_i);
  assign bus.mem_wdata  = b;
  assign halted         = (state == HALT);
  assign fault          = fault_q;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    ir_d      = ir;
    tcnt_d    = tcnt;
    rf_we     = 1'b0;
    rf_wd     = ex_wd;
    retire    = 1'b0;
    fault_set = 1'b0;
    case (state)
      FETCH: begin
        if (bus.instr_ack) begin
          ir_d    = bus.instr_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_ld || is_st) begin
          tcnt_d  = '0;
          state_d = MEM;
        end else begin
          rf_we   = ex_wen;
          retire  = 1'b1;
          pc_d    = ex_nxt;
          state_d = (pc == last_pc) ? HALT : FETCH;
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          rf_we   = is_ld;
          rf_wd   = bus.mem_rdata;
          retire  = 1'b1;
          pc_d    = pc4;
          state_d = (pc == last_pc) ? HALT : FETCH;
        end else if (MEM_TIMEOUT != 0 && tcnt == MEM_TIMEOUT - 1) begin
          fault_set = 1'b1;
          state_d   = HALT;
        end else begin
          tcnt_d = tcnt + 32'd1;
        end
      end
      default: ;
    endcase
    // an instruction abandoned by reset never counts as retired
    if (rst) retire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      tcnt    <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      ir    <= ir_d;
      tcnt  <= tcnt_d;
      if (fault_set) fault_q <= 1'b1;
      if (rf_we && reg_ok(rd)) rf[rd[AW-1:0]] <= rf_wd;
    end
  end
endmodule

// File: tb/tb_core_mc.sv
// Directed bench for core_mc: ALU sequence and halt timing, delayed store/load,
// branch loop, memory timeout, reset during a wait, and a 16-register build.
module tb_core_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] last_pc = 32'd0;
  logic retire, halted, fault;
  logic retire16, halted16, fault16;

  core_mc_if bus();
  core_mc_if bus16();

  core_mc #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .last_pc(last_pc), .bus(bus.master),
    .retire(retire), .halted(halted), .fault(fault)
  );

  core_mc #(.NREGS(16)) dut16 (
    .clk(clk), .rst(rst), .last_pc(32'd8), .bus(bus16.master),
    .retire(retire16), .halted(halted16), .fault(fault16)
  );

  always #5 clk = ~clk;

  // instruction and data memories
  logic [31:0] imem [32];
  logic [31:0] imem16 [4];
  logic [31:0] dmem [16];
  logic        man_mode = 1'b0;
  logic        mack_man = 1'b0;
  logic [3:0]  mcnt;
  logic [3:0]  mdly = 4'd0;

  assign bus.instr_ack   = 1'b1;
  assign bus.instr_data  = imem[bus.instr_addr[6:2]];
  assign bus.mem_rdata   = man_mode ? 32'hCAFE_0000 : dmem[bus.mem_addr[5:2]];
  assign bus.mem_ack     = man_mode ? mack_man : ((bus.mem_re | bus.mem_we) && mcnt == mdly);
  assign bus16.instr_ack  = 1'b1;
  assign bus16.instr_data = imem16[bus16.instr_addr[3:2]];
  assign bus16.mem_rdata  = 32'd0;
  assign bus16.mem_ack    = 1'b0;

  int          wr_cnt, nf;
  logic [31:0] wr_addr, wr_data;
  logic [31:0] fpcs [16];
  int          stab_err, excl_err, we_cyc;
  logic        pv_act;
  logic [65:0] pv;

  always @(posedge clk) begin
    if (rst) begin
      mcnt   <= '0;
      wr_cnt <= 0;
      nf     <= 0;
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
    end else begin
      if ((bus.mem_re | bus.mem_we) && !bus.mem_ack) mcnt <= mcnt + 4'd1;
      else mcnt <= '0;
      if (bus.mem_we && bus.mem_ack) begin
        dmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= bus.mem_addr;
        wr_data <= bus.mem_wdata;
      end
      if (bus.instr_req && bus.instr_ack && nf < 16) begin
        fpcs[nf] <= bus.instr_addr;
        nf       <= nf + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stab_err <= 0;
      excl_err <= 0;
      we_cyc   <= 0;
      pv_act   <= 1'b0;
    end else begin
      if (bus.mem_re && bus.mem_we) excl_err <= excl_err + 1;
      if (bus.mem_we) we_cyc <= we_cyc + 1;
      if (pv_act && pv != {bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata})
        stab_err <= stab_err + 1;
      pv_act <= (bus.mem_re | bus.mem_we) && !bus.mem_ack;
      pv     <= {bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    end
  end

  // instruction encoders
  function automatic logic [31:0] addi(input logic [31:0] rd, rs1, imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] add(input logic [31:0] rd, rs1, rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] lui(input logic [31:0] rd, imm20);
    return {imm20[19:0], rd[4:0], 7'b0110111};
  endfunction
  function automatic logic [31:0] sw(input logic [31:0] rs2, rs1, imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] lw(input logic [31:0] rd, rs1, imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] bne(input logic [31:0] rs1, rs2, imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b001, imm[4:1], imm[11], 7'b1100011};
  endfunction

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 32'd0;
  endtask

  // leaves rst high through two edges, returns at a negedge still in reset
  task automatic hold_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (halted) done = 1'b1;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  int rcount;
  logic [31:0] gold_pc [8];

  initial begin
    imem16[0] = addi(20, 0, 7);
    imem16[1] = add(5, 20, 0);
    imem16[2] = addi(6, 0, 9);
    imem16[3] = 32'd0;

    // ALU sequence, halt timing, reset-state outputs
    clear_imem();
    imem[0] = addi(1, 0, 5);
    imem[1] = addi(2, 0, -3);
    imem[2] = add(3, 1, 2);
    last_pc = 32'd8;
    hold_reset();
    check("rst_instr_req", {31'd0, bus.instr_req}, 32'd1);
    check("rst_instr_addr", bus.instr_addr, 32'd0);
    check("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    rcount = 0;
    check("c1_retire", {31'd0, retire}, 32'd0);
    for (int cyc = 2; cyc <= 8; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (retire) rcount++;
      if (cyc == 6) check("halted_c6", {31'd0, halted}, 32'd0);
      if (cyc == 7) check("halted_c7", {31'd0, halted}, 32'd1);
    end
    check("retire_cnt", rcount, 32'd3);
    check("x1", dut.rf[1], 32'd5);
    check("x2", dut.rf[2], 32'hFFFF_FFFD);
    check("x3", dut.rf[3], 32'd2);
    check("halt_no_req", {31'd0, bus.instr_req}, 32'd0);
    check("n16_halted", {31'd0, halted16}, 32'd1);
    check("n16_x5", dut16.rf[5], 32'd0);
    check("n16_x6", dut16.rf[6], 32'd9);

    // store then load with a 3-cycle ack delay
    clear_imem();
    imem[0] = lui(1, 32'hDEADC);
    imem[1] = addi(1, 1, -32'h111);
    imem[2] = sw(1, 0, 4);
    imem[3] = lw(4, 0, 4);
    imem[4] = addi(0, 0, 9);
    last_pc = 32'd16;
    mdly = 4'd3;
    hold_reset();
    rst = 1'b0;
    wait_halt("halt_ldst", 60);
    check("wr_cnt", wr_cnt, 32'd1);
    check("wr_addr", wr_addr, 32'd4);
    check("wr_data", wr_data, 32'hDEAD_BEEF);
    check("x4_load", dut.rf[4], 32'hDEAD_BEEF);
    check("x0_zero", dut.rf[0], 32'd0);
    check("we_cycles", we_cyc, 32'd4);
    check("mem_stable", stab_err, 32'd0);
    check("re_we_excl", excl_err, 32'd0);
    mdly = 4'd0;

    // BNE loop counting x1 down from 3
    clear_imem();
    imem[0] = addi(1, 0, 3);
    imem[1] = addi(1, 1, -1);
    imem[2] = bne(1, 0, -4);
    imem[3] = addi(2, 0, 1);
    last_pc = 32'd12;
    gold_pc = '{32'd0, 32'd4, 32'd8, 32'd4, 32'd8, 32'd4, 32'd8, 32'd12};
    hold_reset();
    rst = 1'b0;
    wait_halt("halt_loop", 60);
    check("fetch_cnt", nf, 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("pc_seq%0d", i), fpcs[i], gold_pc[i]);
    check("loop_x1", dut.rf[1], 32'd0);
    check("loop_x2", dut.rf[2], 32'd1);

    // load timeout: ack never comes
    clear_imem();
    imem[0] = addi(7, 0, 32'h55);
    imem[1] = lw(7, 0, 0);
    last_pc = 32'd100;
    man_mode = 1'b1;
    mack_man = 1'b0;
    hold_reset();
    rst = 1'b0;
    for (int cyc = 2; cyc <= 9; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 8) begin
        check("to_c8_re", {31'd0, bus.mem_re}, 32'd1);
        check("to_c8_fault", {31'd0, fault}, 32'd0);
      end
      if (cyc == 9) begin
        check("to_fault", {31'd0, fault}, 32'd1);
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_re_off", {31'd0, bus.mem_re}, 32'd0);
      end
    end
    check("to_rd_kept", dut.rf[7], 32'h55);

    // reset arrives together with mem_ack during a load wait
    clear_imem();
    imem[0] = addi(3, 0, 1);
    imem[1] = lw(3, 0, 0);
    hold_reset();
    rst = 1'b0;
    for (int cyc = 2; cyc <= 6; cyc++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_re", {31'd0, bus.mem_re}, 32'd1);
    rst = 1'b1;
    mack_man = 1'b1;
    #1;
    check("rst_ack_retire", {31'd0, retire}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_ack_req", {31'd0, bus.instr_req}, 32'd1);
    check("rst_ack_pc", bus.instr_addr, 32'd0);
    check("rst_ack_x3", dut.rf[3], 32'd0);
    check("rst_ack_re", {31'd0, bus.mem_re}, 32'd0);
    mack_man = 1'b0;
    man_mode = 1'b0;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
